usr_cmd_sequencer: RTL and testbench

Command sequencer and two-port round-robin arbiter for a 4-bit universal shift register. Two requesters each issue LOAD, SHIFT-RIGHT, SHIFT-LEFT or ROTATE-RIGHT commands with a repeat count. The block drives the register's mode, parallel data and serial-in pins cycle by cycle, then returns the final register contents with a done pulse. It sits between bus-side requesters and the shift register, which is instantiated beside it and reset by the same `rst`.

---
 rtl/usr_cmd_sequencer.sv | 171 +++++++++++++++++
 tb/tb_usr_cmd_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/usr_cmd_sequencer.sv
// Two-port round-robin command sequencer for a universal shift register.
// Turns LOAD/SHR/SHL/ROTR commands with repeat counts into per-cycle mode/data/sin drive.
module usr_cmd_sequencer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [1:0]       req0_op,
   input  logic [CNT_W-1:0] req0_cnt,
   input  logic [WIDTH-1:0] req0_data,
   input  logic             req0_fill,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [1:0]       req1_op,
   input  logic [CNT_W-1:0] req1_cnt,
   input  logic [WIDTH-1:0] req1_data,
   input  logic             req1_fill,
   output logic [1:0]       usr_mode,
   output logic [WIDTH-1:0] usr_data,
   output logic             usr_sin,
   input  logic [WIDTH-1:0] usr_q,
   output logic             busy,
   output logic             done,
   output logic             done_id,
   output logic [WIDTH-1:0] result
);

   // state | meaning
   // IDLE  | arbitrate between requesters, accept one command
   // EXEC  | drive one register operation per cycle until remaining hits 0
   // DONE  | register holds; capture result and pulse done on exit
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_SHR  = 2'b01;
   localparam logic [1:0] OP_SHL  = 2'b10;
   localparam logic [1:0] OP_ROTR = 2'b11;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   remaining;
   logic               last_grant;
   logic [1:0]         op_lat;
   logic [WIDTH-1:0]   data_lat;
   logic               fill_lat;
   logic               id_lat;

   logic               grant_id;
   logic               accept;
   logic [1:0]         sel_op;
   logic [CNT_W-1:0]   sel_cnt;
   logic [WIDTH-1:0]   sel_data;
   logic               sel_fill;
   logic [CNT_W-1:0]   load_cnt;

   // On a tie the requester that did not win last time is served.
   always_comb begin
      if (req0_valid && req1_valid) begin
         grant_id = ~last_grant;
      end else begin
         grant_id = req1_valid;
      end
      accept     = (state == ST_IDLE) && (req0_valid || req1_valid);
      req0_ready = accept && !grant_id;
      req1_ready = accept && grant_id;
      sel_op     = grant_id ? req1_op   : req0_op;
      sel_cnt    = grant_id ? req1_cnt  : req0_cnt;
      sel_data   = grant_id ? req1_data : req0_data;
      sel_fill   = grant_id ? req1_fill : req0_fill;
      load_cnt   = (sel_op == OP_LOAD) ? CNT_ONE : sel_cnt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      usr_mode  = MODE_HOLD;
      usr_data  = '0;
      usr_sin   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nxt = (load_cnt != '0) ? ST_EXEC : ST_DONE;
            end
         end
         ST_EXEC: begin
            case (op_lat)
               OP_LOAD: begin
                  usr_mode = MODE_LOAD;
                  usr_data = data_lat;
               end
               OP_SHR: begin
                  usr_mode = MODE_SHR;
                  usr_sin  = fill_lat;
               end
               OP_SHL: begin
                  usr_mode = MODE_SHL;
                  usr_sin  = fill_lat;
               end
               default: begin
                  // rotate right: feed the bit leaving the LSB back into the MSB
                  usr_mode = MODE_SHR;
                  usr_sin  = usr_q[0];
               end
            endcase
            if (remaining <= CNT_ONE) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         remaining  <= '0;
         last_grant <= 1'b1;
         op_lat     <= OP_LOAD;
         data_lat   <= '0;
         fill_lat   <= 1'b0;
         id_lat     <= 1'b0;
         done       <= 1'b0;
         done_id    <= 1'b0;
         result     <= '0;
      end else begin
         done <= (state == ST_DONE);
         if (accept) begin
            op_lat     <= sel_op;
            data_lat   <= sel_data;
            fill_lat   <= sel_fill;
            id_lat     <= grant_id;
            last_grant <= grant_id;
            remaining  <= load_cnt;
         end else if ((state == ST_EXEC) && (remaining != '0)) begin
            remaining <= remaining - CNT_ONE;
         end
         if (state == ST_DONE) begin
            result  <= usr_q;
            done_id <= id_lat;
         end
      end
   end

endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// Bench for usr_cmd_sequencer: models the attached shift register and predicts
// each command's outcome arithmetically.
module tb_usr_cmd_sequencer;

   localparam int W = 4;
   localparam int C = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic           req0_valid, req1_valid;
   logic           req0_ready, req1_ready;
   logic [1:0]     req0_op, req1_op;
   logic [C-1:0]   req0_cnt, req1_cnt;
   logic [W-1:0]   req0_data, req1_data;
   logic           req0_fill, req1_fill;
   logic [1:0]     usr_mode;
   logic [W-1:0]   usr_data;
   logic           usr_sin;
   logic [W-1:0]   reg_q;
   logic           busy, done, done_id;
   logic [W-1:0]   result;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   usr_cmd_sequencer #(.WIDTH(W), .CNT_W(C)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_cnt(req0_cnt), .req0_data(req0_data), .req0_fill(req0_fill),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_cnt(req1_cnt), .req1_data(req1_data), .req1_fill(req1_fill),
      .usr_mode(usr_mode), .usr_data(usr_data), .usr_sin(usr_sin), .usr_q(reg_q),
      .busy(busy), .done(done), .done_id(done_id), .result(result)
   );

   // the universal shift register sitting beside the sequencer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) reg_q <= '0;
      else begin
         case (usr_mode)
            2'b01:   reg_q <= {usr_sin, reg_q[W-1:1]};
            2'b10:   reg_q <= {reg_q[W-2:0], usr_sin};
            2'b11:   reg_q <= usr_data;
            default: reg_q <= reg_q;
         endcase
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_result(int start, int op, int cnt, int data, int fill);
      int v = start;
      int r;
      case (op)
         0: v = data;
         1: for (int k = 0; k < cnt; k++) v = (v >> 1) + fill * 8;
         2: for (int k = 0; k < cnt; k++) v = (v * 2 + fill) % 16;
         default: begin
            r = cnt % W;
            v = ((start >> r) | (start << (W - r))) % 16;
         end
      endcase
      return v;
   endfunction

   function automatic int exp_mode(int op);
      case (op)
         0: return 3;
         2: return 2;
         default: return 1;
      endcase
   endfunction

   task automatic drive(input int id, input int op, input int cnt, input int data, input int fill);
      if (id == 0) begin
         req0_valid = 1'b1; req0_op = op[1:0]; req0_cnt = cnt[C-1:0];
         req0_data = data[W-1:0]; req0_fill = fill[0];
      end else begin
         req1_valid = 1'b1; req1_op = op[1:0]; req1_cnt = cnt[C-1:0];
         req1_data = data[W-1:0]; req1_fill = fill[0];
      end
   endtask

   // called at handshake edge + 1; follows the command through to its done pulse
   task automatic track(input int id, input int op, input int cnt, input int data,
                        input int fill, input int start);
      int n       = (op == 0) ? 1 : cnt;
      int done_at = -1;
      int busy_n  = 0;
      int act_n   = 0;
      for (int i = 0; i < 20 && done_at < 0; i++) begin
         if (i > 0) begin
            @(posedge clk);
            #1;
         end
         if (busy) busy_n++;
         if (usr_mode != 2'b00) act_n++;
         if (i < n) begin
            check("exec_mode", usr_mode, exp_mode(op));
            if (op == 0) check("exec_data", usr_data, data);
            else if (op == 3) check("rotr_sin", usr_sin, reg_q[0]);
            else check("shift_sin", usr_sin, fill);
         end else begin
            check("idle_drive", {usr_mode, usr_data, usr_sin}, 0);
         end
         if (done) done_at = i;
      end
      check("done_latency", done_at, n + 1);
      check("done_id", done_id, id);
      check("result", result, ref_result(start, op, cnt, data, fill));
      check("busy_cycles", busy_n, n + 1);
      check("op_cycles", act_n, n);
      @(posedge clk);
      #1;
      check("done_single", done, 0);
   endtask

   // entered at posedge + 1 with the bench idle and no valid raised
   task automatic issue(input int id, input int op, input int cnt, input int data, input int fill);
      int start;
      drive(id, op, cnt, data, fill);
      #1;
      check("ready_granted", id == 0 ? req0_ready : req1_ready, 1);
      check("ready_other", id == 0 ? req1_ready : req0_ready, 0);
      start = int'(reg_q);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      track(id, op, cnt, data, fill, start);
   endtask

   initial begin
      int exp_lg;
      int g;
      rst = 1'b1;
      req0_valid = 0; req0_op = 0; req0_cnt = 0; req0_data = 0; req0_fill = 0;
      req1_valid = 0; req1_op = 0; req1_cnt = 0; req1_data = 0; req1_fill = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_drive", {usr_mode, usr_data, usr_sin}, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_done_id", done_id, 0);
      check("rst_result", result, 0);
      rst = 1'b0;

      issue(0, 0, 0, 4'b1011, 0);
      issue(1, 0, 0, 4'b0000, 0);
      issue(1, 1, 2, 0, 1);
      issue(0, 0, 0, 4'b1011, 0);
      issue(0, 2, 3, 0, 0);
      issue(0, 0, 0, 4'b1011, 0);
      issue(1, 3, 5, 0, 0);

      // both requesters held with count 0: grants must alternate starting with req0
      rst = 1'b1;
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      drive(0, 1, 0, 0, 0);
      drive(1, 2, 0, 0, 1);
      exp_lg = 1;
      for (int k = 0; k < 4; k++) begin
         #1;
         g = 1 - exp_lg;
         check("tie_ready0", req0_ready, g == 0);
         check("tie_ready1", req1_ready, g == 1);
         @(posedge clk);
         exp_lg = g;
         #1;
         check("tie_busy", busy, 1);
         check("tie_mode_done", usr_mode, 0);
         @(posedge clk);
         #1;
         if (k == 3) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
         end
         check("tie_done", done, 1);
         check("tie_done_id", done_id, g);
         check("tie_result", result, ref_result(0, 1, 0, 0, 0));
         check("tie_mode_idle", usr_mode, 0);
      end
      @(posedge clk);
      #1;

      // reset in the middle of a long shift; held valid is re-accepted afterwards
      drive(0, 2, 7, 0, 1);
      @(posedge clk);
      #1;
      repeat (2) begin
         @(posedge clk);
         #1;
         check("pre_rst_mode", usr_mode, 2);
      end
      rst = 1'b1;
      #1;
      check("rst_mid_drive", {usr_mode, usr_data, usr_sin}, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_done", done, 0);
      @(posedge clk);
      #1;
      check("rst_hold_done", done, 0);
      #1;
      rst = 1'b0;
      #1;
      check("reaccept_ready", req0_ready, 1);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      track(0, 2, 7, 0, 1, 0);

      for (int k = 0; k < 40; k++) begin
         issue(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
